uart_char_receiver: RTL and testbench

- Input-side counterpart of the text display path: receives 8N1 serial characters on a UART RX pin and produces the `cin`/`we` character stream that the display controller consumes.
- One received character gives one byte on `cin` with a single-cycle `we` strobe.
- Sits between the board RX pin and the display controller; it has no backpressure because the display side accepts one character per `we`.

---
 rtl/uart_pkg.sv | 8 +
 rtl/baud_tick_gen.sv | 19 +
 rtl/uart_char_receiver.sv | 106 ++++++++++
 tb/tb_uart_char_receiver.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver types, constants and divisor helper
package uart_pkg;
    localparam int DATA_W = 8;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
    function automatic int calc_divisor(input int clk_freq, input int baud, input int oversample);
        return clk_freq / (baud * oversample);
    endfunction
endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: divides clk into one-cycle sample ticks, restartable via clear
module baud_tick_gen #(
    parameter int DIVISOR = 651
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int CW = DIVISOR > 1 ? $clog2(DIVISOR) : 1;
    logic [CW-1:0] r_cnt;
    assign tick = !clear && (r_cnt == CW'(DIVISOR - 1));
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_cnt <= '0;
        else
            r_cnt <= (clear || tick) ? '0 : r_cnt + 1'b1;
    end
endmodule

// File: rtl/uart_char_receiver.sv
// uart_char_receiver: 8N1 UART receiver producing a cin/we character stream
module uart_char_receiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    output logic [DATA_W-1:0] cin,
    output logic              we,
    output logic              frame_err,
    output logic              busy
);
    localparam int DIVISOR = calc_divisor(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int SW      = $clog2(OVERSAMPLE);
    localparam int BW      = $clog2(DATA_W);
    state_t            r_state, w_state_n;
    logic              r_rx_meta, r_rxs;
    logic [SW-1:0]     r_smp, w_smp_n;
    logic [BW-1:0]     r_bit, w_bit_n;
    logic [DATA_W-1:0] r_shift, w_shift_n, r_cin, w_cin_n;
    logic              r_we, w_we_n, r_fe, w_fe_n;
    logic              w_tick, w_clear, w_smp_last;
    // holding the divider in IDLE aligns every sample to the detected start edge
    assign w_clear = (r_state == IDLE);
    baud_tick_gen #(.DIVISOR(DIVISOR)) u_tick (
        .clk  (clk),
        .reset(reset),
        .clear(w_clear),
        .tick (w_tick)
    );
    assign w_smp_last = (r_smp == SW'(OVERSAMPLE - 1));
    always_comb begin
        w_state_n = r_state;
        w_smp_n   = r_smp;
        w_bit_n   = r_bit;
        w_shift_n = r_shift;
        w_cin_n   = r_cin;
        w_we_n    = 1'b0;
        w_fe_n    = 1'b0;
        case (r_state)
            IDLE: begin
                w_smp_n = '0;
                w_bit_n = '0;
                w_state_n = r_rxs ? IDLE : START;
            end
            START: if (w_tick) begin
                w_smp_n = r_smp + 1'b1;
                if (r_smp == SW'(OVERSAMPLE / 2 - 1)) begin
                    w_smp_n   = '0;
                    w_state_n = r_rxs ? IDLE : DATA;
                end
            end
            DATA: if (w_tick) begin
                w_smp_n = r_smp + 1'b1;
                if (w_smp_last) begin
                    w_smp_n   = '0;
                    w_shift_n = {r_rxs, r_shift[DATA_W-1:1]};
                    w_bit_n   = r_bit + 1'b1;
                    w_state_n = (r_bit == BW'(DATA_W - 1)) ? STOP : DATA;
                end
            end
            STOP: if (w_tick) begin
                w_smp_n = r_smp + 1'b1;
                if (w_smp_last) begin
                    w_cin_n   = r_rxs ? r_shift : r_cin;
                    w_we_n    = r_rxs;
                    w_fe_n    = !r_rxs;
                    w_state_n = r_rxs ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: w_state_n = r_rxs ? IDLE : WAIT_HIGH;
            default:   w_state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
            r_state   <= IDLE;
            r_smp     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_cin     <= '0;
            r_we      <= 1'b0;
            r_fe      <= 1'b0;
        end else begin
            r_rx_meta <= rx;
            r_rxs     <= r_rx_meta;
            r_state   <= w_state_n;
            r_smp     <= w_smp_n;
            r_bit     <= w_bit_n;
            r_shift   <= w_shift_n;
            r_cin     <= w_cin_n;
            r_we      <= w_we_n;
            r_fe      <= w_fe_n;
        end
    end
    assign cin       = r_cin;
    assign we        = r_we;
    assign frame_err = r_fe;
    assign busy      = (r_state != IDLE);
endmodule

// File: tb/tb_uart_char_receiver.sv
// tb_uart_char_receiver: table-driven and randomized frames against a frame-level reference model
module tb_uart_char_receiver;
    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 10_000;
    localparam int OS       = 16;
    localparam int BIT      = 160;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         hold;
        int         gap;
        int         exp_we;
        int         exp_fe;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] cin;
    logic       we, frame_err, busy;

    uart_char_receiver #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .cin      (cin),
        .we       (we),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int cyc = 0, t_start = 0;
    int n_we = 0, n_fe = 0, n_both = 0, n_wide = 0, we_cyc = 0;
    logic [7:0] we_cin = 8'h00, model_cin = 8'h00;
    logic prev_we = 1'b0, prev_fe = 1'b0;
    vec_t vecs[7];

    always @(posedge clk) cyc <= cyc + 1;

    // strobe monitor: records each pulse and counts protocol violations
    always @(negedge clk) begin
        if (we && frame_err) n_both++;
        if ((we && prev_we) || (frame_err && prev_fe)) n_wide++;
        if (we) begin
            n_we++;
            we_cin = cin;
            we_cyc = cyc;
        end
        if (frame_err) n_fe++;
        prev_we = we;
        prev_fe = frame_err;
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic stop, input int hold);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        t_start = cyc;
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (BIT) @(negedge clk);
        end
        if (!stop) repeat (hold) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        int we0, fe0;
        we0 = n_we;
        fe0 = n_fe;
        send(v.data, v.stop, v.hold);
        check("we_count", n_we - we0, v.exp_we);
        check("fe_count", n_fe - fe0, v.exp_fe);
        if (v.exp_we == 1) begin
            model_cin = v.data;
            check("we_cin", int'(we_cin), int'(v.data));
            check("latency_ok", int'((we_cyc - t_start) >= 1520 && (we_cyc - t_start) <= 1525), 1);
            check("busy_after_stop", int'(busy), 0);
        end
        repeat (v.gap) @(negedge clk);
        if (v.exp_fe == 1) check("busy_after_break", int'(busy), 0);
        check("cin_hold", int'(cin), int'(model_cin));
    endtask

    initial begin
        int we0, fe0;
        logic [9:0] f;
        vec_t rv;
        vecs[0] = '{8'h41, 1'b1,   0, 200, 1, 0};
        vecs[1] = '{8'h48, 1'b1,   0,   0, 1, 0};
        vecs[2] = '{8'h69, 1'b1,   0,   0, 1, 0};
        vecs[3] = '{8'h00, 1'b1,   0,   0, 1, 0};
        vecs[4] = '{8'hFF, 1'b1,   0, 100, 1, 0};
        vecs[5] = '{8'h55, 1'b0, 400,  50, 0, 1};
        vecs[6] = '{8'h0D, 1'b1,   0, 100, 1, 0};

        repeat (5) @(negedge clk);
        check("rst_cin", int'(cin), 0);
        check("rst_we", int'(we), 0);
        check("rst_fe", int'(frame_err), 0);
        check("rst_busy", int'(busy), 0);
        reset = 1'b1;
        repeat (50) @(negedge clk);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        we0 = n_we;
        fe0 = n_fe;
        rx = 1'b0;
        repeat (30) @(negedge clk);
        check("glitch_busy_mid", int'(busy), 1);
        rx = 1'b1;
        repeat (80) @(negedge clk);
        check("glitch_busy", int'(busy), 0);
        check("glitch_we", n_we - we0, 0);
        check("glitch_fe", n_fe - fe0, 0);
        repeat (50) @(negedge clk);

        for (int i = 5; i < 7; i++) run_vec(vecs[i]);

        f = {1'b1, 8'h3C, 1'b0};
        for (int i = 0; i < 5; i++) begin
            rx = f[i];
            repeat (BIT) @(negedge clk);
        end
        rx = f[5];
        repeat (BIT / 2) @(negedge clk);
        check("pre_reset_busy", int'(busy), 1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_cin", int'(cin), 0);
        check("async_rst_we", int'(we), 0);
        check("async_rst_busy", int'(busy), 0);
        model_cin = 8'h00;
        @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        reset = 1'b1;
        repeat (200) @(negedge clk);
        rv = '{8'h3C, 1'b1, 0, 50, 1, 0};
        run_vec(rv);

        for (int i = 0; i < 6; i++) begin
            rv.data   = 8'($urandom);
            rv.stop   = ($urandom_range(0, 4) != 0);
            rv.hold   = $urandom_range(0, 300);
            rv.gap    = rv.stop ? $urandom_range(0, 40) : $urandom_range(10, 40);
            rv.exp_we = rv.stop ? 1 : 0;
            rv.exp_fe = rv.stop ? 0 : 1;
            run_vec(rv);
        end

        check("never_both_strobes", n_both, 0);
        check("single_cycle_strobes", n_wide, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
